asic_mem_responder: RTL and testbench

- Memory-side responder for the accelerator's MEM REQ/MEM RESP interface: accepts load/store requests and returns exactly one response per accepted request.
- Backed by an internal 64-bit-word scratchpad.
- Used as the memory model behind the matrix-vector multiplier in block- and system-level benches, and as an on-chip scratchpad in small configurations.
- Fully pipelined with fixed latency: one request per cycle, no backpressure on responses (the RESP interface has no ready).

---
 rtl/asic_mem_responder.sv | 147 ++++++++++++++
 tb/tb_asic_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asic_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : asic_mem_responder
// Brief    : Fixed-latency, fully pipelined load/store responder backed by a
//            64-bit-word scratchpad; one response per accepted request.
// Revision : 1.0 - initial release
// ============================================================================
module asic_mem_responder #(
   parameter int XLEN        = 64,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req_ready_o,
   input  logic            mem_req_valid_i,
   input  logic [39:0]     mem_req_addr_i,
   input  logic [4:0]      mem_req_cmd_i,
   input  logic [2:0]      mem_req_typ_i,
   input  logic [XLEN-1:0] mem_req_data_i,
   output logic            mem_resp_valid_o,
   output logic [39:0]     mem_resp_addr_o,
   output logic [4:0]      mem_resp_cmd_o,
   output logic [2:0]      mem_resp_typ_o,
   output logic [XLEN-1:0] mem_resp_data_o,
   output logic            mem_resp_err_o
);

   localparam int c_idx_w = $clog2(DEPTH_WORDS);

   logic [XLEN-1:0]    r_mem [DEPTH_WORDS];
   logic               r_ready;
   logic               r_vld  [LATENCY];
   logic [39:0]        r_addr [LATENCY];
   logic [4:0]         r_cmd  [LATENCY];
   logic [2:0]         r_typ  [LATENCY];
   logic [XLEN-1:0]    r_data [LATENCY];
   logic               r_err  [LATENCY];

   logic [c_idx_w-1:0] w_idx;
   logic [2:0]         w_off;
   logic [7:0]         w_mask;
   logic [7:0]         w_be;
   logic               w_misalign;
   logic               w_oor;
   logic               w_badcmd;
   logic               w_err;
   logic               w_accept;
   logic               w_wr_en;
   logic [XLEN-1:0]    w_wdata;
   logic [XLEN-1:0]    w_sh;
   logic [XLEN-1:0]    w_ld;
   logic [XLEN-1:0]    w_resp_data;

   assign w_idx    = mem_req_addr_i[c_idx_w+2:3];
   assign w_off    = mem_req_addr_i[2:0];
   assign w_oor    = |mem_req_addr_i[39:c_idx_w+3];
   assign w_badcmd = (mem_req_cmd_i > 5'd1);
   assign w_err    = w_misalign | w_oor | w_badcmd;
   assign w_accept = mem_req_valid_i & r_ready;
   assign w_wr_en  = w_accept & (mem_req_cmd_i == 5'd1) & ~w_err;
   assign w_be     = w_mask << w_off;
   assign w_wdata  = mem_req_data_i << {w_off, 3'b000};
   assign w_sh     = r_mem[w_idx] >> {w_off, 3'b000};

   // Size decode, alignment and load extraction; typ[2] selects zero-extension.
   always_comb begin
      w_mask     = 8'h01;
      w_misalign = 1'b0;
      w_ld       = w_sh;
      case (mem_req_typ_i[1:0])
         2'd0: begin
            w_mask = 8'h01;
            w_ld   = mem_req_typ_i[2] ? {56'b0, w_sh[7:0]} : {{56{w_sh[7]}}, w_sh[7:0]};
         end
         2'd1: begin
            w_mask     = 8'h03;
            w_misalign = w_off[0];
            w_ld       = mem_req_typ_i[2] ? {48'b0, w_sh[15:0]} : {{48{w_sh[15]}}, w_sh[15:0]};
         end
         2'd2: begin
            w_mask     = 8'h0F;
            w_misalign = |w_off[1:0];
            w_ld       = mem_req_typ_i[2] ? {32'b0, w_sh[31:0]} : {{32{w_sh[31]}}, w_sh[31:0]};
         end
         default: begin
            w_mask     = 8'hFF;
            w_misalign = |w_off;
            w_ld       = w_sh;
         end
      endcase
      w_resp_data = (w_err || mem_req_cmd_i != 5'd0) ? '0 : w_ld;
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < 8; b++) begin
            if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   // Payload only advances alongside a valid, so the last stage holds between pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready <= 1'b0;
         for (int i = 0; i < LATENCY; i++) begin
            r_vld[i]  <= 1'b0;
            r_addr[i] <= '0;
            r_cmd[i]  <= '0;
            r_typ[i]  <= '0;
            r_data[i] <= '0;
            r_err[i]  <= 1'b0;
         end
      end else begin
         r_ready  <= 1'b1;
         r_vld[0] <= w_accept;
         if (w_accept) begin
            r_addr[0] <= mem_req_addr_i;
            r_cmd[0]  <= mem_req_cmd_i;
            r_typ[0]  <= mem_req_typ_i;
            r_data[0] <= w_resp_data;
            r_err[0]  <= w_err;
         end
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            if (r_vld[i-1]) begin
               r_addr[i] <= r_addr[i-1];
               r_cmd[i]  <= r_cmd[i-1];
               r_typ[i]  <= r_typ[i-1];
               r_data[i] <= r_data[i-1];
               r_err[i]  <= r_err[i-1];
            end
         end
      end
   end

   assign mem_req_ready_o  = r_ready;
   assign mem_resp_valid_o = r_vld[LATENCY-1];
   assign mem_resp_addr_o  = r_addr[LATENCY-1];
   assign mem_resp_cmd_o   = r_cmd[LATENCY-1];
   assign mem_resp_typ_o   = r_typ[LATENCY-1];
   assign mem_resp_data_o  = r_data[LATENCY-1];
   assign mem_resp_err_o   = r_err[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_asic_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_asic_mem_responder
// Brief    : Bench driving three responders (LATENCY 1/2/3) with shared
//            stimulus against a byte-array memory model and response schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asic_mem_responder;

   localparam int DEPTH = 256;

   typedef struct packed {
      logic [39:0] addr;
      logic [4:0]  cmd;
      logic [2:0]  typ;
      logic [63:0] data;
      logic        err;
   } resp_t;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        req_valid = 1'b0;
   logic [39:0] req_addr  = '0;
   logic [4:0]  req_cmd   = '0;
   logic [2:0]  req_typ   = '0;
   logic [63:0] req_data  = '0;

   logic        rdy   [1:3];
   logic        rv    [1:3];
   logic [39:0] raddr [1:3];
   logic [4:0]  rcmd  [1:3];
   logic [2:0]  rtyp  [1:3];
   logic [63:0] rdata [1:3];
   logic        rerr  [1:3];

   int          vectors     = 0;
   int          miscompares = 0;
   int          edge_n      = 0;
   bit          m_ready     = 1'b0;
   logic [7:0]  mem_b   [DEPTH*8];
   logic        sched_v [1:3][8];
   resp_t       sched_r [1:3][8];
   resp_t       last_r  [1:3];
   logic [63:0] cap_data = '0;
   logic        cap_err  = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 1; g <= 3; g++) begin : g_dut
      asic_mem_responder #(.XLEN(64), .DEPTH_WORDS(DEPTH), .LATENCY(g)) u_dut (
         .clk              (clk),
         .reset            (reset),
         .mem_req_ready_o  (rdy[g]),
         .mem_req_valid_i  (req_valid),
         .mem_req_addr_i   (req_addr),
         .mem_req_cmd_i    (req_cmd),
         .mem_req_typ_i    (req_typ),
         .mem_req_data_i   (req_data),
         .mem_resp_valid_o (rv[g]),
         .mem_resp_addr_o  (raddr[g]),
         .mem_resp_cmd_o   (rcmd[g]),
         .mem_resp_typ_o   (rtyp[g]),
         .mem_resp_data_o  (rdata[g]),
         .mem_resp_err_o   (rerr[g])
      );
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int l = 1; l <= 3; l++) begin
         last_r[l] = '0;
         for (int s = 0; s < 8; s++) sched_v[l][s] = 1'b0;
      end
   endtask

   // Reference semantics on a flat byte array; response due LATENCY-1 edges later.
   task automatic model_accept();
      resp_t       r;
      int          sz;
      int          off;
      int          a;
      logic [63:0] v;
      r.addr = req_addr;
      r.cmd  = req_cmd;
      r.typ  = req_typ;
      r.data = '0;
      sz     = 1 << req_typ[1:0];
      off    = int'(req_addr[2:0]);
      r.err  = ((off % sz) != 0) || (req_addr >= 40'(DEPTH*8)) || (req_cmd > 5'd1);
      if (!r.err) begin
         a = int'(req_addr[31:0]);
         if (req_cmd == 5'd0) begin
            v = '0;
            for (int b = 0; b < sz; b++) v = v | (64'(mem_b[a+b]) << (8*b));
            if (!req_typ[2] && sz < 8 && v[8*sz-1]) v = v | (~64'(0) << (8*sz));
            r.data = v;
         end else begin
            for (int b = 0; b < sz; b++) mem_b[a+b] = req_data[8*b +: 8];
         end
      end
      for (int l = 1; l <= 3; l++) begin
         sched_v[l][(edge_n + l - 1) % 8] = 1'b1;
         sched_r[l][(edge_n + l - 1) % 8] = r;
      end
   endtask

   task automatic check_cycle();
      int s;
      bit ev;
      s = edge_n % 8;
      for (int l = 1; l <= 3; l++) begin
         ev = sched_v[l][s];
         if (ev) begin
            last_r[l]     = sched_r[l][s];
            sched_v[l][s] = 1'b0;
         end
         chk($sformatf("L%0d ready", l), 64'(rdy[l]),   64'(m_ready));
         chk($sformatf("L%0d valid", l), 64'(rv[l]),    64'(ev));
         chk($sformatf("L%0d addr", l),  64'(raddr[l]), 64'(last_r[l].addr));
         chk($sformatf("L%0d cmd", l),   64'(rcmd[l]),  64'(last_r[l].cmd));
         chk($sformatf("L%0d typ", l),   64'(rtyp[l]),  64'(last_r[l].typ));
         chk($sformatf("L%0d data", l),  rdata[l],      last_r[l].data);
         chk($sformatf("L%0d err", l),   64'(rerr[l]),  64'(last_r[l].err));
      end
      if (rv[2] === 1'b1) begin
         cap_data = rdata[2];
         cap_err  = rerr[2];
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         if (reset) begin
            if (req_valid && m_ready) model_accept();
            m_ready = 1'b1;
         end
         #1;
         check_cycle();
      end
   end

   task automatic req(input logic [4:0] cmd, input logic [2:0] typ,
                      input logic [39:0] addr, input logic [63:0] data);
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_typ   = typ;
      req_addr  = addr;
      req_data  = data;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input int n, input bit check);
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 1'b0;
      m_ready   = 1'b0;
      model_clear();
      #1;
      if (check) chk("ready drops async", 64'(rdy[2]), 64'd0);
      repeat (n) @(negedge clk);
      reset = 1'b1;
      if (check) begin
         @(posedge clk);
         #2;
         chk("ready after release", 64'(rdy[2]), 64'd1);
      end
   endtask

   task automatic lit(input string name, input logic [63:0] exp_data, input logic exp_err);
      chk({name, " data"}, cap_data, exp_data);
      chk({name, " err"}, 64'(cap_err), 64'(exp_err));
   endtask

   initial begin
      logic [2:0]  typ;
      logic [39:0] addr;
      logic [4:0]  cmd;
      int          sz;
      model_clear();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      idle(2);

      for (int i = 0; i < DEPTH; i++) req(5'd1, 3'd3, 40'(i*8), {$urandom, $urandom});
      idle(4);

      req(5'd1, 3'd3, 40'h10, 64'h1122334455667788); idle(4);
      lit("store D resp", 64'h0, 1'b0);
      req(5'd0, 3'd3, 40'h10, '0); idle(4);
      lit("load D 0x10", 64'h1122334455667788, 1'b0);

      req(5'd1, 3'd0, 40'h13, 64'h80); idle(4);
      req(5'd0, 3'd0, 40'h13, '0); idle(4);
      lit("load B 0x13", 64'hFFFFFFFFFFFFFF80, 1'b0);
      req(5'd0, 3'd4, 40'h13, '0); idle(4);
      lit("load BU 0x13", 64'h0000000000000080, 1'b0);
      req(5'd0, 3'd3, 40'h10, '0); idle(4);
      lit("merged word", 64'h1122334480667788, 1'b0);

      req(5'd0, 3'd1, 40'h11, '0); idle(4);
      lit("misaligned H", 64'h0, 1'b1);
      req(5'd1, 3'd2, 40'h16, 64'hDEADBEEF); idle(4);
      lit("misaligned W store", 64'h0, 1'b1);
      req(5'd0, 3'd3, 40'h800, '0); idle(4);
      lit("out of range", 64'h0, 1'b1);
      req(5'd5, 3'd3, 40'h10, '0); idle(4);
      lit("bad cmd", 64'h0, 1'b1);
      req(5'd0, 3'd3, 40'h10, '0); idle(4);
      lit("unchanged after errors", 64'h1122334480667788, 1'b0);

      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) req(5'd1, 3'd3, 40'(i*8), 64'hA5A5000000000000 | 64'(i));
         else            req(5'd0, 3'd3, 40'((i-1)*8), '0);
      end
      idle(5);
      lit("b2b last load", 64'hA5A5000000000006, 1'b0);

      req(5'd1, 3'd3, 40'h40, 64'hCAFEF00D12345678);
      req(5'd0, 3'd3, 40'h40, '0);
      do_reset(3, 1'b1);
      req(5'd0, 3'd3, 40'h40, '0); idle(4);
      lit("store survives reset", 64'hCAFEF00D12345678, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            typ  = 3'($urandom_range(0, 7));
            sz   = 1 << typ[1:0];
            addr = 40'($urandom_range(0, DEPTH-1) * 8);
            if ($urandom_range(0, 7) == 0) addr[2:0] = 3'($urandom_range(0, 7));
            else                           addr[2:0] = 3'($urandom_range(0, 7) & ~(sz-1));
            if ($urandom_range(0, 15) == 0) addr[$urandom_range(11, 39)] = 1'b1;
            cmd = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 1));
            req(cmd, typ, addr, {$urandom, $urandom});
         end
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
